// File: rtl/seg_scan_ctrl_pkg.sv
// Shared display definitions for the seven-segment scan controller.
// Holds the digit-index width and the active-low {g,f,e,d,c,b,a} hex patterns.
// Imported by hex7seg and seg_scan_ctrl.
package seg_scan_ctrl_pkg;

  localparam int SEL_W = 3;

  // Active-low, common-anode patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_A   = 7'h08;
  localparam logic [6:0] SEG_B   = 7'h03;  // lowercase b
  localparam logic [6:0] SEG_C   = 7'h46;
  localparam logic [6:0] SEG_D   = 7'h21;  // lowercase d
  localparam logic [6:0] SEG_E   = 7'h06;
  localparam logic [6:0] SEG_F   = 7'h0E;

endpackage

// File: rtl/hex7seg.sv
// Purpose: combinational 4-bit nibble to active-low seven-segment pattern.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows input.
// Ports: nib_i (4) nibble to display; seg_n_o (7) pattern {g,f,e,d,c,b,a}, active-low.
module hex7seg
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_n_o
);

  always_comb begin
    seg_n_o = SEG_OFF;
    case (nib_i)
      4'h0: seg_n_o = SEG_0;
      4'h1: seg_n_o = SEG_1;
      4'h2: seg_n_o = SEG_2;
      4'h3: seg_n_o = SEG_3;
      4'h4: seg_n_o = SEG_4;
      4'h5: seg_n_o = SEG_5;
      4'h6: seg_n_o = SEG_6;
      4'h7: seg_n_o = SEG_7;
      4'h8: seg_n_o = SEG_8;
      4'h9: seg_n_o = SEG_9;
      4'hA: seg_n_o = SEG_A;
      4'hB: seg_n_o = SEG_B;
      4'hC: seg_n_o = SEG_C;
      4'hD: seg_n_o = SEG_D;
      4'hE: seg_n_o = SEG_E;
      4'hF: seg_n_o = SEG_F;
      default: seg_n_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Purpose: time-multiplexed 8-digit seven-segment scan controller for the debug display.
// Latency: seg_n_o/dp_n_o are registered and lag sel_o by one clock; the blanking window hides the lag.
// Backpressure: none; load_i is a one-cycle strobe always accepted.
// Ports: clk, rst_n (async active-low); data_i (32) display word, nibble k on digit k;
//   load_i strobe capturing data_i/dp_i; dp_i (8) decimal points, active-high;
//   sel_o (3) digit index to decoder38; seg_n_o (7) {g,f,e,d,c,b,a} active-low; dp_n_o active-low.
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int CLK_DIV    = 100000,
  parameter int NUM_DIGITS = 8,
  parameter int GHOST_CYC  = 2
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      data_i,
  input  logic             load_i,
  input  logic [7:0]       dp_i,
  output logic [SEL_W-1:0] sel_o,
  output logic [6:0]       seg_n_o,
  output logic             dp_n_o
);

  localparam int PRE_W = $clog2(CLK_DIV);

  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_nxt;
  logic             tick;
  logic             blank_nxt;
  logic             last_dig;
  logic [31:0]      shadow_q;
  logic [7:0]       shadow_dp_q;
  logic [3:0]       nib;
  logic [6:0]       hex_pat;
  logic [6:0]       seg_pat;
  logic             dp_bit;

  assign tick     = (pre_q == PRE_W'(CLK_DIV - 1));
  assign pre_nxt  = tick ? '0 : pre_q + 1'b1;
  assign last_dig = (sel_o == SEL_W'(NUM_DIGITS - 1));

  // Blanking is decided on the prescaler value the output register will
  // coincide with, so the first clock of a slot (where sel_o has already
  // moved but the pattern would still be the previous digit's) is dark.
  assign blank_nxt = (pre_nxt < PRE_W'(GHOST_CYC));

  assign nib    = shadow_q[{sel_o, 2'b00} +: 4];
  assign dp_bit = shadow_dp_q[sel_o];

  hex7seg u_hex7seg (
    .nib_i   (nib),
    .seg_n_o (hex_pat)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // lead_zero[k] is set when nibble k and every scanned nibble above it are zero.
  logic [7:0] lead_zero;

  always_comb begin
    logic run;
    run       = 1'b1;
    lead_zero = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      run          = run & (shadow_q[4*k +: 4] == 4'h0);
      lead_zero[k] = run;
    end
  end

  assign seg_pat = (lead_zero[sel_o] && (sel_o != '0)) ? SEG_OFF : hex_pat;
`else
  assign seg_pat = hex_pat;
`endif

  // Prescaler: free-running, never disturbed by loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_nxt;
    end
  end

  // Scan index advances once per slot and wraps at the last scanned digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_o <= '0;
    end else if (tick) begin
      sel_o <= last_dig ? '0 : sel_o + 1'b1;
    end
  end

  // Shadow registers; a load coinciding with a tick is fine because the
  // new slot's first pattern is only sampled after the blanking clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q    <= '0;
      shadow_dp_q <= '0;
    end else if (load_i) begin
      shadow_q    <= data_i;
      shadow_dp_q <= dp_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_n_o <= SEG_OFF;
      dp_n_o  <= 1'b1;
    end else if (blank_nxt) begin
      seg_n_o <= SEG_OFF;
      dp_n_o  <= 1'b1;
    end else begin
      seg_n_o <= seg_pat;
      dp_n_o  <= ~dp_bit;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with CLK_DIV=4, GHOST_CYC=1, NUM_DIGITS=8.
// A time-based model (cycles since reset -> slot and digit) predicts every output each cycle;
// directed literal checks pin the model at known points.
module tb_seg_scan_ctrl;

  localparam int CD = 4;
  localparam int GC = 1;
  localparam int ND = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load_i = 1'b0;
  logic [31:0] data_i = '0;
  logic [7:0]  dp_i = '0;
  logic [2:0]  sel_o;
  logic [6:0]  seg_n_o;
  logic        dp_n_o;

  int checks = 0;
  int errors = 0;

  // Model state.
  int          cyc;
  logic [31:0] m_shadow;
  logic [7:0]  m_dp;
  logic [2:0]  exp_sel;
  logic [6:0]  exp_seg;
  logic        exp_dp;

  logic [6:0] lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg_scan_ctrl #(.CLK_DIV(CD), .NUM_DIGITS(ND), .GHOST_CYC(GC)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_i  (data_i),
    .load_i  (load_i),
    .dp_i    (dp_i),
    .sel_o   (sel_o),
    .seg_n_o (seg_n_o),
    .dp_n_o  (dp_n_o)
  );

  always #5 clk = ~clk;

  function automatic int sel_of(int c);
    return (c / CD) % ND;
  endfunction

  // What digit k must look like for a given shadow word.
  function automatic logic [6:0] digit_view(logic [31:0] sh, int k);
    logic [31:0] upper;
    logic [3:0]  n;
    upper = sh >> (4 * k);
    n     = upper[3:0];
`ifdef LEADING_ZERO_BLANK_EN
    if (k != 0 && upper == 32'd0) return 7'h7F;
`endif
    return lut[n];
  endfunction

  // Time-based model: slot index and phase follow from the cycle count.
  // A pattern shown at cycle c is that of the digit and shadow at cycle c-1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc      <= 0;
      m_shadow <= '0;
      m_dp     <= '0;
      exp_sel  <= '0;
      exp_seg  <= 7'h7F;
      exp_dp   <= 1'b1;
    end else begin
      cyc     <= cyc + 1;
      exp_sel <= 3'(sel_of(cyc + 1));
      if (((cyc + 1) % CD) < GC) begin
        exp_seg <= 7'h7F;
        exp_dp  <= 1'b1;
      end else begin
        exp_seg <= digit_view(m_shadow, sel_of(cyc));
        exp_dp  <= ~m_dp[sel_of(cyc)];
      end
      if (load_i) begin
        m_shadow <= data_i;
        m_dp     <= dp_i;
      end
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    check("model_sel", 32'(sel_o), 32'(exp_sel));
    check("model_seg", 32'(seg_n_o), 32'(exp_seg));
    check("model_dp", 32'(dp_n_o), 32'(exp_dp));
  end

  task automatic wait_phase(int s, int p);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (sel_of(cyc) == s && (cyc % CD) == p) hit = 1'b1;
    end
    if (!hit) begin
      errors++;
      $display("FAIL wait_phase: digit %0d phase %0d not reached, got cyc %0d required match", s, p, cyc);
    end
  endtask

  task automatic do_load(logic [31:0] d, logic [7:0] dp);
    data_i = d;
    dp_i   = dp;
    load_i = 1'b1;
    @(negedge clk);
    load_i = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_sel", 32'(sel_o), 32'd0);
    check("rst_seg", 32'(seg_n_o), 32'h7F);
    check("rst_dp", 32'(dp_n_o), 32'd1);
    rst_n = 1'b1;

    // No load: digit 0 shows "0".
    wait_phase(0, 2);
    check("idle_d0", 32'(seg_n_o), 32'h40);

    // Scan of 89ABCDEF.
    do_load(32'h89ABCDEF, 8'h00);
    wait_phase(0, 1);
    check("scan_d0_F", 32'(seg_n_o), 32'h0E);
    wait_phase(1, 0);
    check("ghost_d1", 32'(seg_n_o), 32'h7F);
    check("ghost_sel1", 32'(sel_o), 32'd1);
    wait_phase(1, 1);
    check("scan_d1_E", 32'(seg_n_o), 32'h06);
    wait_phase(7, 2);
    check("scan_d7_8", 32'(seg_n_o), 32'h00);
    check("scan_sel7", 32'(sel_o), 32'd7);
    wait_phase(0, 0);
    check("wrap_sel0", 32'(sel_o), 32'd0);

    // Load coincident with the tick.
    wait_phase(3, CD - 1);
    do_load(32'h00000001, 8'h00);
    wait_phase(4, 1);
`ifdef LEADING_ZERO_BLANK_EN
    check("tickload_d4", 32'(seg_n_o), 32'h7F);
`else
    check("tickload_d4", 32'(seg_n_o), 32'h40);
`endif
    wait_phase(0, 1);
    check("tickload_d0", 32'(seg_n_o), 32'h79);

    // Decimal point on digit 2 only.
    do_load(32'h12345678, 8'h04);
    wait_phase(2, 0);
    check("dp_ghost", 32'(dp_n_o), 32'd1);
    wait_phase(2, 1);
    check("dp_d2_on", 32'(dp_n_o), 32'd0);
    check("dp_d2_seg", 32'(seg_n_o), 32'h02);
    wait_phase(3, 1);
    check("dp_d3_off", 32'(dp_n_o), 32'd1);

    // Mid-scan asynchronous reset, with a load attempted while held.
    wait_phase(5, 2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_sel", 32'(sel_o), 32'd0);
    check("arst_seg", 32'(seg_n_o), 32'h7F);
    check("arst_dp", 32'(dp_n_o), 32'd1);
    data_i = 32'hFFFFFFFF;
    dp_i   = 8'hFF;
    load_i = 1'b1;
    @(negedge clk);
    load_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_phase(0, 1);
    check("arst_shadow_d0", 32'(seg_n_o), 32'h40);
    wait_phase(2, 1);
    check("arst_dp_clear", 32'(dp_n_o), 32'd1);

    // Randomized loads, including repeats and words with leading zeros.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        data_i = $urandom >> $urandom_range(0, 31);
        dp_i   = 8'($urandom);
      end
      load_i = ($urandom_range(0, 7) == 0);
      @(negedge clk);
    end
    load_i = 1'b0;

    // Leading-zero handling on 00000120.
    do_load(32'h00000120, 8'h00);
    wait_phase(7, 1);
`ifdef LEADING_ZERO_BLANK_EN
    check("lzb_d7", 32'(seg_n_o), 32'h7F);
    wait_phase(0, 1);
    check("lzb_d0", 32'(seg_n_o), 32'h40);
    wait_phase(1, 1);
    check("lzb_d1", 32'(seg_n_o), 32'h24);
    wait_phase(2, 1);
    check("lzb_d2", 32'(seg_n_o), 32'h79);
    wait_phase(3, 1);
    check("lzb_d3", 32'(seg_n_o), 32'h7F);
`else
    check("nolzb_d7", 32'(seg_n_o), 32'h40);
    wait_phase(2, 1);
    check("nolzb_d2", 32'(seg_n_o), 32'h79);
    wait_phase(3, 1);
    check("nolzb_d3", 32'(seg_n_o), 32'h40);
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
